// File: rtl/dip_event_responder_pkg.sv
// Shared definitions for the DIP event responder: register offsets, default window base
// and the per-switch debounce states.
package dip_event_responder_pkg;

    localparam logic [1:0] OFF_DATA  = 2'd0;
    localparam logic [1:0] OFF_EVENT = 2'd1;
    localparam logic [1:0] OFF_MASK  = 2'd2;
    localparam logic [1:0] OFF_COUNT = 2'd3;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0C10;

    typedef enum logic {
        StIdle,
        StCounting
    } debState_e;

endpackage

// File: rtl/dip_event_responder_if.sv
// Core IO load/store bus as seen by a memory-mapped peripheral.
interface dip_event_responder_if;

    logic [31:0] ADDR;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;

    modport master (output ADDR, output WE, output WD, input RD);
    modport slave (input ADDR, input WE, input WD, output RD);

endinterface

// File: rtl/dip_event_responder_debounce_bit.sv
// One switch input: synchroniser chain followed by a hold-time debounce FSM that
// accepts a new level only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
module dip_event_responder_debounce_bit
    import dip_event_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic CLK,
    input  logic Reset,
    input  logic din,
    output logic stable,
    output logic chg
);

    localparam logic [15:0] LastCnt = 16'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncQ;
    logic                   syncBit;
    debState_e              stateQ, stateD;
    logic [15:0]            cntQ, cntD;
    logic                   stableQ, stableD;
    logic                   chgQ, chgD;

    assign syncBit = syncQ[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            syncQ   <= '0;
            stateQ  <= StIdle;
            cntQ    <= '0;
            stableQ <= 1'b0;
            chgQ    <= 1'b0;
        end else begin
            syncQ   <= {syncQ[SYNC_STAGES-2:0], din};
            stateQ  <= stateD;
            cntQ    <= cntD;
            stableQ <= stableD;
            chgQ    <= chgD;
        end
    end

    always_comb begin
        stateD  = stateQ;
        cntD    = cntQ;
        stableD = stableQ;
        chgD    = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (syncBit != stableQ) begin
                    stateD = StCounting;
                    cntD   = 16'd1;
                end else begin
                    cntD = '0;
                end
            end
            StCounting: begin
                if (syncBit == stableQ) begin
                    stateD = StIdle;
                    cntD   = '0;
                end else if (cntQ == LastCnt) begin
                    // chg is registered so it lines up with the new stable level
                    stableD = syncBit;
                    chgD    = 1'b1;
                    stateD  = StIdle;
                    cntD    = '0;
                end else begin
                    cntD = cntQ + 16'd1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    assign stable = stableQ;
    assign chg    = chgQ;

endmodule

// File: rtl/dip_event_responder.sv
// DIP switch responder on the core IO bus: debounced levels, sticky change events,
// change counter and a maskable attention line.
module dip_event_responder
    import dip_event_responder_pkg::*;
#(
    parameter int unsigned WIDTH           = 7,
    parameter logic [31:0] BASE_ADDR       = DEFAULT_BASE_ADDR,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic [WIDTH-1:0]       DIP,
    dip_event_responder_if.slave   io,
    output logic                   IRQ
);

    logic [WIDTH-1:0] stable, chg;
    logic [WIDTH-1:0] eventQ, eventD, maskQ, maskD, clr;
    logic [15:0]      countQ, countD;
    logic             hit, wrHit;
    logic [1:0]       off;
    logic [31:0]      rdData;
    logic             unusedBits;

    for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
        dip_event_responder_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .CLK   (CLK),
            .Reset (Reset),
            .din   (DIP[i]),
            .stable(stable[i]),
            .chg   (chg[i])
        );
    end

    assign hit        = (io.ADDR[31:4] == BASE_ADDR[31:4]);
    assign off        = io.ADDR[3:2];
    assign wrHit      = io.WE && hit;
    assign unusedBits = ^{io.ADDR[1:0], io.WD[31:WIDTH]};

    always_comb begin
        clr    = (wrHit && off == OFF_EVENT) ? io.WD[WIDTH-1:0] : '0;
        // set wins over a simultaneous W1C on the same bit
        eventD = (eventQ & ~clr) | chg;
        maskD  = (wrHit && off == OFF_MASK) ? io.WD[WIDTH-1:0] : maskQ;
        if (wrHit && off == OFF_COUNT) begin
            countD = {15'b0, |chg};
        end else if (|chg) begin
            countD = countQ + 16'd1;
        end else begin
            countD = countQ;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            eventQ <= '0;
            maskQ  <= '0;
            countQ <= '0;
        end else begin
            eventQ <= eventD;
            maskQ  <= maskD;
            countQ <= countD;
        end
    end

    always_comb begin
        rdData = '0;
        if (hit) begin
            unique case (off)
                OFF_DATA:  rdData = 32'(stable);
                OFF_EVENT: rdData = 32'(eventQ);
                OFF_MASK:  rdData = 32'(maskQ);
                OFF_COUNT: rdData = {16'b0, countQ};
                default:   rdData = '0;
            endcase
        end
    end

    assign io.RD = rdData;
    assign IRQ   = |(eventQ & maskQ);

endmodule

// File: tb/tb_dip_event_responder.sv
// Bench for dip_event_responder: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural register/debounce model.
module tb_dip_event_responder;

    localparam int unsigned W    = 7;
    localparam int unsigned D    = 4;
    localparam int unsigned S    = 2;
    localparam logic [31:0] BASE = 32'h0000_0C10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] dip = '0;
    logic         irq;

    dip_event_responder_if io ();

    always #5 clk = ~clk;

    dip_event_responder #(
        .WIDTH          (W),
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .CLK  (clk),
        .Reset(rst),
        .DIP  (dip),
        .io   (io),
        .IRQ  (irq)
    );

    int errors = 0;
    int checks = 0;

    // Model: a level is accepted once it has differed from the accepted level for D
    // consecutive sampled cycles; samples reach the debouncer S cycles after DIP.
    logic [W-1:0] mStable, mEvent, mMask, mChg;
    logic [15:0]  mCount;
    int           mRun[W];
    logic [W-1:0] mPipe[$];
    bit           checkEn = 0;

    function automatic logic [31:0] expRd(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd0:    return 32'(mStable);
            2'd1:    return 32'(mEvent);
            2'd2:    return 32'(mMask);
            default: return {16'h0, mCount};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    task automatic modelStep();
        logic         hit;
        logic [1:0]   off;
        logic [W-1:0] s;
        logic [W-1:0] newChg;
        if (rst) begin
            mStable = '0;
            mEvent  = '0;
            mMask   = '0;
            mChg    = '0;
            mCount  = '0;
            mPipe   = {};
            for (int i = 0; i < int'(S); i++) mPipe.push_back('0);
            for (int i = 0; i < int'(W); i++) mRun[i] = 0;
        end else begin
            hit = (io.ADDR[31:4] == BASE[31:4]);
            off = io.ADDR[3:2];
            if (io.WE && hit && off == 2'd1) mEvent = mEvent & ~io.WD[W-1:0];
            mEvent = mEvent | mChg;
            if (io.WE && hit && off == 2'd2) mMask = io.WD[W-1:0];
            if (io.WE && hit && off == 2'd3) mCount = (mChg != 0) ? 16'd1 : 16'd0;
            else if (mChg != 0) mCount = mCount + 16'd1;
            s = mPipe.pop_front();
            mPipe.push_back(dip);
            newChg = '0;
            for (int i = 0; i < int'(W); i++) begin
                if (s[i] != mStable[i]) begin
                    mRun[i]++;
                    if (mRun[i] == int'(D)) begin
                        mStable[i] = s[i];
                        newChg[i]  = 1'b1;
                        mRun[i]    = 0;
                    end
                end else begin
                    mRun[i] = 0;
                end
            end
            mChg = newChg;
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            check("rd_model", io.RD, expRd(io.ADDR));
            check("irq_model", 32'(irq), 32'(|(mEvent & mMask)));
        end
    end

    task automatic step(input logic [W-1:0] d, input logic [31:0] a, input logic we,
                        input logic [31:0] wd, input logic r);
        @(posedge clk);
        modelStep();
        checkEn = 1;
        #1;
        dip     = d;
        io.ADDR = a;
        io.WE   = we;
        io.WD   = wd;
        rst     = r;
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a);
        step(dip, a, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        step(dip, a, 1'b1, wd, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) rd(BASE);
    endtask

    initial begin
        logic [W-1:0] d;
        logic [31:0]  a;
        int           r;
        io.ADDR = BASE;
        io.WE   = 1'b0;
        io.WD   = '0;
        for (int k = 0; k < 3; k++) step('0, BASE, 1'b0, 32'h0, 1'b1);
        step('0, BASE, 1'b0, 32'h0, 1'b0);

        // Reset state
        for (int k = 0; k < 4; k++) begin
            rd(BASE + 32'(4 * k));
            check("reset_reg", io.RD, 32'h0);
        end
        check("reset_irq", 32'(irq), 32'h0);
        rd(32'h0000_0C20);
        check("nonhit_rd", io.RD, 32'h0);

        // Clean rising edge on bit 0: DATA updates exactly D+S cycles later
        step(7'b0000001, BASE, 1'b0, 32'h0, 1'b0);
        idle(5);
        check("data_before_latency", io.RD, 32'h0);
        idle(1);
        check("data_at_latency", io.RD, 32'h1);
        idle(1);
        rd(BASE + 32'h4);
        check("event_bit0", io.RD, 32'h1);
        rd(BASE + 32'hC);
        check("count_one", io.RD, 32'h1);

        // 3-cycle glitch on bit 2 is rejected
        step(7'b0000101, BASE, 1'b0, 32'h0, 1'b0);
        idle(2);
        step(7'b0000001, BASE, 1'b0, 32'h0, 1'b0);
        idle(8);
        check("glitch_data", io.RD, 32'h1);
        rd(BASE + 32'h4);
        check("glitch_event", io.RD, 32'h1);
        rd(BASE + 32'hC);
        check("glitch_count", io.RD, 32'h1);

        // Mask, W1C, and set-wins-over-clear
        wr(BASE + 32'h8, 32'hFFFF_FF01);
        rd(BASE + 32'h8);
        check("mask_rd", io.RD, 32'h1);
        check("irq_masked", 32'(irq), 32'h1);
        wr(BASE + 32'h4, 32'h1);
        rd(BASE + 32'h4);
        check("irq_after_w1c", 32'(irq), 32'h0);
        step(7'b0000000, BASE, 1'b0, 32'h0, 1'b0);
        idle(5);
        wr(BASE + 32'h4, 32'h1);
        rd(BASE + 32'h4);
        check("set_wins_event", io.RD, 32'h1);
        rd(BASE + 32'hC);
        check("count_two", io.RD, 32'h2);

        // Simultaneous change on bits 1 and 3 counts once
        wr(BASE + 32'h4, 32'h7F);
        step(7'b0001010, BASE, 1'b0, 32'h0, 1'b0);
        idle(8);
        rd(BASE + 32'h4);
        check("event_pair", io.RD, 32'h0A);
        rd(BASE + 32'hC);
        check("count_pair", io.RD, 32'h3);

        // Counter wrap from a preloaded value
        idle(2);
        force dut.countQ = 16'hFFFE;
        mCount = 16'hFFFE;
        idle(1);
        release dut.countQ;
        step(7'b0001000, BASE, 1'b0, 32'h0, 1'b0);
        idle(7);
        rd(BASE + 32'hC);
        check("count_ffff", io.RD, 32'hFFFF);
        step(7'b0001010, BASE, 1'b0, 32'h0, 1'b0);
        idle(7);
        rd(BASE + 32'hC);
        check("count_wrap", io.RD, 32'h0);

        // COUNT clear concurrent with a change leaves 1
        step(7'b0000010, BASE, 1'b0, 32'h0, 1'b0);
        idle(5);
        wr(BASE + 32'hC, 32'h1234_5678);
        rd(BASE + 32'hC);
        check("count_clr_with_chg", io.RD, 32'h1);

        // Reset mid-debounce aborts; power-up levels are then reported
        step(7'b0010010, BASE, 1'b0, 32'h0, 1'b0);
        idle(3);
        step(dip, BASE, 1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(dip, BASE + 32'(4 * k), 1'b0, 32'h0, 1'b0);
            check("midreset_reg", io.RD, 32'h0);
        end
        idle(8);
        check("powerup_data", io.RD, 32'h12);
        rd(BASE + 32'h4);
        check("powerup_event", io.RD, 32'h12);
        rd(BASE + 32'hC);
        check("powerup_count", io.RD, 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            d = dip;
            if ($urandom_range(0, 9) == 0) begin
                r = int'($urandom_range(0, W - 1));
                d[r] = ~d[r];
            end
            r = int'($urandom_range(0, 5));
            if (r < 4) a = BASE + 32'(4 * r) + 32'($urandom_range(0, 3));
            else if (r == 4) a = BASE + 32'h10 * 32'($urandom_range(1, 4));
            else a = BASE ^ 32'h8000_0000;
            step(d, a, ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 499) == 0));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
